hyst_cmp_bank: RTL and testbench

- Clocked, multi-channel comparator bank with selectable regular, hysteresis (Schmitt) or hysteresis-plus-debounce mode.
- Each channel takes an unsigned fixed-point sample and produces a registered logic level, plus rise/fall event pulses.
- Sits between ADC sample capture and the digital control/monitor logic.
- Replaces per-signal analog-model Schmitt blocks with one synthesizable, parametrised bank.

---
 rtl/hyst_cmp_pkg.sv | 23 ++
 rtl/hyst_cmp_chan.sv | 98 +++++++++
 rtl/hyst_cmp_bank.sv | 81 ++++++++
 tb/tb_hyst_cmp_bank.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyst_cmp_pkg.sv
// hyst_cmp_pkg
// Shared types and helpers for the hysteresis comparator bank.
//   mode_e      : comparator operating mode as driven on the bank's mode port
//   eff_deb_len : effective debounce length (a programmed length of 0 acts as 1)
//   DEF_*       : default widths used by the bank and its channels
package hyst_cmp_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_DW    = 12;
    localparam int DEF_DEB_W = 4;

    typedef enum logic [1:0] {
        REGULAR  = 2'd0,
        HYST     = 2'd1,
        HYST_DEB = 2'd2,
        RSVD     = 2'd3
    } mode_e;

    function automatic int eff_deb_len(input int len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/hyst_cmp_chan.sv
// hyst_cmp_chan
// One comparator channel: state flop, debounce counter, next-state logic and
// rise/fall event generation. Shared threshold math lives in the bank.
//   clk, rst_n : clock, synchronous active-low reset
//   proc       : evaluate smp this cycle (valid sample, thresholds consistent)
//   cnt_clr    : mode changed; the debounce count restarts from zero
//   mode       : operating mode
//   thr_lo/hi  : hysteresis thresholds
//   mid        : regular-mode switch point, DW+1 bits
//   deb_eff    : effective debounce length (never 0)
//   smp        : this channel's sample
//   lvl        : registered level (state, optionally inverted)
//   rise/fall  : one-cycle pulses on internal state 0->1 / 1->0
module hyst_cmp_chan
    import hyst_cmp_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int DEB_W  = DEF_DEB_W,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             proc,
    input  logic             cnt_clr,
    input  mode_e            mode,
    input  logic [DW-1:0]    thr_lo,
    input  logic [DW-1:0]    thr_hi,
    input  logic [DW:0]      mid,
    input  logic [DEB_W-1:0] deb_eff,
    input  logic [DW-1:0]    smp,
    output logic             lvl,
    output logic             rise,
    output logic             fall
);

    logic             state;
    logic             state_nxt;
    logic [DEB_W-1:0] cnt;
    logic [DEB_W-1:0] cnt_nxt;
    logic [DEB_W-1:0] cnt_base;
    logic [DEB_W-1:0] cnt_inc;
    logic             qual;

    always_comb begin
        // A mode change restarts the count; a sample in that same cycle
        // is still evaluated, starting from zero.
        cnt_base  = cnt_clr ? '0 : cnt;
        cnt_inc   = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
        qual      = state ? (smp < thr_lo) : (smp > thr_hi);
        state_nxt = state;
        cnt_nxt   = cnt_base;
        if (proc) begin
            case (mode)
                REGULAR: begin
                    state_nxt = ({1'b0, smp} > mid);
                    cnt_nxt   = '0;
                end
                HYST_DEB: begin
                    if (qual) begin
                        // >= so a shortened deb_len mid-run still fires
                        if (cnt_inc >= deb_eff) begin
                            state_nxt = ~state;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                default: begin
                    if (qual) begin
                        state_nxt = ~state;
                    end
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    // stage p0 -> p1: registered state, level and events
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= 1'b0;
            cnt   <= '0;
            lvl   <= INVERT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lvl   <= state_nxt ^ INVERT;
            rise  <= ~state & state_nxt;
            fall  <= state & ~state_nxt;
        end
    end

endmodule

// File: rtl/hyst_cmp_bank.sv
// hyst_cmp_bank
// Multi-channel comparator bank with regular, hysteresis and
// hysteresis-plus-debounce modes; one-clock latency from sample to level.
//   clk, rst_n : clock, synchronous active-low reset
//   mode       : 0 regular, 1 hysteresis, 2 hysteresis+debounce, 3 as 1
//   thr_lo/hi  : shared thresholds (unsigned, DW bits)
//   deb_len    : debounce length, 0 behaves as 1
//   s_valid    : sample strobe common to all channels
//   s_data     : packed samples, channel k at [k*DW +: DW]
//   lvl        : registered level per channel (inverted when INVERT=1)
//   rise/fall  : per-channel one-cycle state-change pulses
//   cfg_err    : registered, high while thr_lo > thr_hi
module hyst_cmp_bank
    import hyst_cmp_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int DW     = DEF_DW,
    parameter int DEB_W  = DEF_DEB_W,
    parameter bit INVERT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [DW-1:0]     thr_lo,
    input  logic [DW-1:0]     thr_hi,
    input  logic [DEB_W-1:0]  deb_len,
    input  logic              s_valid,
    input  logic [NCH*DW-1:0] s_data,
    output logic [NCH-1:0]    lvl,
    output logic [NCH-1:0]    rise,
    output logic [NCH-1:0]    fall,
    output logic              cfg_err
);

    logic [1:0]       mode_p1;
    logic             mode_chg;
    logic             proc;
    logic [DW:0]      mid;
    logic [DEB_W-1:0] deb_eff;

    // Both operands widened to DW+1 bits so the sum cannot wrap.
    assign mid      = ({1'b0, thr_lo} + {1'b0, thr_hi}) >> 1;
    assign mode_chg = (mode != mode_p1);
    // cfg_err is the registered flag, so a bad threshold pair is seen
    // one cycle late and normal operation resumes one cycle after repair.
    assign proc     = s_valid & ~cfg_err;
    assign deb_eff  = DEB_W'(eff_deb_len(int'(deb_len)));

    // stage p0 -> p1: previous mode and configuration check
    always_ff @(posedge clk) begin
        mode_p1 <= mode;
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (thr_lo > thr_hi);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        hyst_cmp_chan #(
            .DW     (DW),
            .DEB_W  (DEB_W),
            .INVERT (INVERT)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .proc    (proc),
            .cnt_clr (mode_chg),
            .mode    (mode_e'(mode)),
            .thr_lo  (thr_lo),
            .thr_hi  (thr_hi),
            .mid     (mid),
            .deb_eff (deb_eff),
            .smp     (s_data[k*DW +: DW]),
            .lvl     (lvl[k]),
            .rise    (rise[k]),
            .fall    (fall[k])
        );
    end

endmodule

// File: tb/tb_hyst_cmp_bank.sv
// tb_hyst_cmp_bank
// Bench for hyst_cmp_bank: a normal and an inverted-level instance share all
// inputs; a behavioural model is compared every cycle, and directed
// sequences pin literal expectations.
module tb_hyst_cmp_bank;

    localparam int NCH   = 4;
    localparam int DW    = 12;
    localparam int DEB_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        mode;
    logic [DW-1:0]     thr_lo;
    logic [DW-1:0]     thr_hi;
    logic [DEB_W-1:0]  deb_len;
    logic              s_valid;
    logic [NCH*DW-1:0] s_data;
    logic [NCH-1:0]    lvl, rise, fall;
    logic [NCH-1:0]    lvl_i, rise_i, fall_i;
    logic              cfg_err, cfg_err_i;

    int checks   = 0;
    int failures = 0;

    hyst_cmp_bank #(.NCH(NCH), .DW(DW), .DEB_W(DEB_W), .INVERT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .thr_lo(thr_lo), .thr_hi(thr_hi),
        .deb_len(deb_len), .s_valid(s_valid), .s_data(s_data),
        .lvl(lvl), .rise(rise), .fall(fall), .cfg_err(cfg_err)
    );

    hyst_cmp_bank #(.NCH(NCH), .DW(DW), .DEB_W(DEB_W), .INVERT(1'b1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .mode(mode), .thr_lo(thr_lo), .thr_hi(thr_hi),
        .deb_len(deb_len), .s_valid(s_valid), .s_data(s_data),
        .lvl(lvl_i), .rise(rise_i), .fall(fall_i), .cfg_err(cfg_err_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int             m_st [NCH];
    int             m_cnt[NCH];
    logic [NCH-1:0] m_lvl, m_lvl_i, m_rise, m_fall;
    logic           m_cfg;
    int             m_mode_prev = 0;
    bit             live = 1'b0;

    function automatic bit crosses(input int st, input int smp, input int lo, input int hi);
        return (st != 0) ? (smp < lo) : (smp > hi);
    endfunction

    always @(posedge clk) begin
        int smp, nxt, lim, lo, hi;
        bit gate;
        lo = int'(thr_lo);
        hi = int'(thr_hi);
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                m_st[k]  = 0;
                m_cnt[k] = 0;
            end
            m_rise = '0;
            m_fall = '0;
            m_cfg  = 1'b0;
            live   = 1'b1;
        end else begin
            gate   = s_valid && !m_cfg;
            m_rise = '0;
            m_fall = '0;
            lim    = (deb_len == 0) ? 1 : int'(deb_len);
            for (int k = 0; k < NCH; k++) begin
                if (int'(mode) != m_mode_prev) m_cnt[k] = 0;
                if (gate) begin
                    smp = int'(s_data[k*DW +: DW]);
                    nxt = m_st[k];
                    if (mode == 2'd0) begin
                        nxt = (smp > (lo + hi) / 2) ? 1 : 0;
                    end else if (mode == 2'd2) begin
                        if (crosses(m_st[k], smp, lo, hi)) begin
                            m_cnt[k] = (m_cnt[k] < 15) ? m_cnt[k] + 1 : 15;
                            if (m_cnt[k] >= lim) begin
                                nxt      = 1 - m_st[k];
                                m_cnt[k] = 0;
                            end
                        end else begin
                            m_cnt[k] = 0;
                        end
                    end else begin
                        if (crosses(m_st[k], smp, lo, hi)) nxt = 1 - m_st[k];
                    end
                    if (nxt == 1 && m_st[k] == 0) m_rise[k] = 1'b1;
                    if (nxt == 0 && m_st[k] == 1) m_fall[k] = 1'b1;
                    m_st[k] = nxt;
                end
            end
            m_cfg = (thr_lo > thr_hi);
        end
        m_mode_prev = int'(mode);
        for (int k = 0; k < NCH; k++) begin
            m_lvl[k]   = (m_st[k] != 0);
            m_lvl_i[k] = (m_st[k] == 0);
        end
        #1;
        if (live) begin
            chk("lvl",       32'(lvl),       32'(m_lvl));
            chk("rise",      32'(rise),      32'(m_rise));
            chk("fall",      32'(fall),      32'(m_fall));
            chk("cfg_err",   32'(cfg_err),   32'(m_cfg));
            chk("lvl_inv",   32'(lvl_i),     32'(m_lvl_i));
            chk("rise_inv",  32'(rise_i),    32'(m_rise));
            chk("fall_inv",  32'(fall_i),    32'(m_fall));
            chk("cfg_inv",   32'(cfg_err_i), 32'(m_cfg));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit v, input logic [NCH*DW-1:0] d);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [NCH*DW-1:0] all4(input int v);
        logic [DW-1:0] x;
        x = DW'(v);
        return {NCH{x}};
    endfunction

    function automatic logic [NCH*DW-1:0] ch0(input int v);
        logic [NCH*DW-1:0] r;
        r         = '0;
        r[DW-1:0] = DW'(v);
        return r;
    endfunction

    function automatic int clampv(input int x);
        return (x < 0) ? 0 : ((x > 4095) ? 4095 : x);
    endfunction

    // ---------------- directed + random sequences ----------------
    initial begin
        int nrise, lo, hi, sel;
        logic [NCH*DW-1:0] d;
        rst_n = 1'b0; mode = 2'd0; thr_lo = 12'd800; thr_hi = 12'd3200;
        deb_len = 4'd3; s_valid = 1'b0; s_data = '0;
        step(0, '0);
        step(0, '0);
        chk("rst_lvl",     32'(lvl),     0);
        chk("rst_rise",    32'(rise),    0);
        chk("rst_fall",    32'(fall),    0);
        chk("rst_cfg",     32'(cfg_err), 0);
        chk("rst_lvl_inv", 32'(lvl_i),   15);
        rst_n = 1'b1;

        // regular mode ramp, mid = 2000
        nrise = 0;
        for (int v = 0; v <= 4000; v += 100) begin
            step(1, all4(v));
            if (rise != '0) nrise++;
            if (v == 2000) chk("reg_at_mid", 32'(lvl), 0);
            if (v == 2100) begin
                chk("reg_2100_lvl",  32'(lvl),  15);
                chk("reg_2100_rise", 32'(rise), 15);
            end
        end
        step(1, all4(4095));
        chk("reg_rise_count", 32'(nrise), 1);

        // hysteresis
        mode = 2'd1;
        step(0, '0);
        step(1, all4(700));
        chk("hyst_fall700", 32'(fall), 15);
        step(1, all4(3100));
        step(1, all4(3200));
        chk("hyst_at_hi", 32'(lvl), 0);
        step(1, all4(3300));
        chk("hyst_3300_lvl",  32'(lvl),  15);
        chk("hyst_3300_rise", 32'(rise), 15);
        step(1, all4(2000));
        chk("hyst_dip_lvl", 32'(lvl), 15);
        step(1, all4(3300));
        chk("hyst_back_rise", 32'(rise), 0);
        step(1, all4(2000));
        step(1, all4(1000));
        step(1, all4(800));
        chk("hyst_at_lo", 32'(lvl), 15);
        step(1, all4(700));
        chk("hyst_700_lvl",  32'(lvl),  0);
        chk("hyst_700_fall", 32'(fall), 15);

        // debounce, deb_len = 3, with idle gaps
        mode = 2'd2; deb_len = 4'd3;
        step(0, '0);
        step(1, ch0(3300)); step(0, '0);
        step(1, ch0(3300)); step(1, ch0(100)); step(0, '0);
        step(1, ch0(3300)); step(0, '0);
        step(1, ch0(3300));
        chk("deb_5th_lvl", 32'(lvl), 0);
        step(0, '0); step(0, '0);
        step(1, ch0(3300));
        chk("deb_6th_lvl",  32'(lvl),  1);
        chk("deb_6th_rise", 32'(rise), 1);
        deb_len = 4'd0;
        step(1, ch0(700));
        chk("deb0_fall", 32'(fall), 1);
        deb_len = 4'd1;
        step(1, ch0(3300));
        chk("deb1_rise", 32'(rise), 1);

        // all channels crossing together
        mode = 2'd1;
        step(0, '0);
        step(1, all4(100));
        chk("multi_fall0", 32'(fall), 1);
        step(1, all4(3300));
        chk("multi_rise",    32'(rise),  15);
        chk("multi_lvl_inv", 32'(lvl_i), 0);
        step(1, all4(3300));
        chk("multi_once", 32'(rise), 0);

        // configuration error freezes the bank
        thr_lo = 12'd3000; thr_hi = 12'd1000;
        step(0, '0);
        chk("cfg_set", 32'(cfg_err), 1);
        for (int i = 0; i < 10; i++) begin
            step(1, all4((i % 2) ? 4000 : 100));
            chk("cfg_frozen_lvl",  32'(lvl),  15);
            chk("cfg_frozen_fall", 32'(fall), 0);
        end
        thr_lo = 12'd800; thr_hi = 12'd3200;
        step(0, '0);
        chk("cfg_clr", 32'(cfg_err), 0);
        step(1, all4(100));
        chk("cfg_resume_fall", 32'(fall), 15);

        // mode change mid-count
        mode = 2'd2; deb_len = 4'd3;
        step(0, '0);
        step(1, ch0(3300)); step(1, ch0(3300));
        chk("mc_count2_lvl", 32'(lvl), 0);
        mode = 2'd1;
        step(0, '0);
        step(1, ch0(3300));
        chk("mc_hyst_rise", 32'(rise), 1);
        mode = 2'd2;
        step(0, '0);
        step(1, ch0(100)); step(1, ch0(100));
        mode = 2'd0; step(0, '0);
        mode = 2'd2; step(0, '0);
        step(1, ch0(100));
        chk("mc_cleared_lvl", 32'(lvl), 1);

        // reset mid-operation with count 2 pending
        step(1, ch0(100));
        rst_n = 1'b0;
        step(0, '0);
        chk("mid_rst_lvl",     32'(lvl),   0);
        chk("mid_rst_lvl_inv", 32'(lvl_i), 15);
        rst_n = 1'b1;
        step(1, ch0(3300)); step(1, ch0(3300));
        chk("post_rst_lvl2", 32'(lvl), 0);
        step(1, ch0(3300));
        chk("post_rst_rise", 32'(rise), 1);

        // randomized phase, model checks every cycle
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                lo = $urandom_range(0, 4095);
                hi = $urandom_range(0, 4095);
                if ($urandom_range(0, 3) != 0 && lo > hi) begin
                    sel = lo; lo = hi; hi = sel;
                end
                if ($urandom_range(0, 15) == 0) hi = lo;
                thr_lo = DW'(lo); thr_hi = DW'(hi);
            end
            if ($urandom_range(0, 49) == 0) deb_len = DEB_W'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < NCH; k++) begin
                sel = $urandom_range(0, 7);
                case (sel)
                    0: d[k*DW +: DW] = DW'(clampv(int'(thr_lo) - 1));
                    1: d[k*DW +: DW] = thr_lo;
                    2: d[k*DW +: DW] = DW'(clampv(int'(thr_lo) + 1));
                    3: d[k*DW +: DW] = DW'(clampv(int'(thr_hi) - 1));
                    4: d[k*DW +: DW] = thr_hi;
                    5: d[k*DW +: DW] = DW'(clampv(int'(thr_hi) + 1));
                    6: d[k*DW +: DW] = DW'((int'(thr_lo) + int'(thr_hi)) / 2);
                    default: d[k*DW +: DW] = DW'($urandom_range(0, 4095));
                endcase
            end
            step($urandom_range(0, 3) != 0, d);
        end
        rst_n = 1'b1;
        step(0, '0);
        step(0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
